matrix_input_ctrl: RTL and testbench

MATRIX_INPUT_CTRL -- requirements
Module: matrix_input_ctrl

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_input_ctrl_idle_timer.sv | 29 ++
 rtl/matrix_input_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_matrix_input_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared matrix definitions: controller state encoding, default sizes and
// a dimension legality helper, used by matrix_input_ctrl and matrix_storage.
package matrix_pkg;

  localparam int MAX_DIM_DEF    = 5;
  localparam int ELEM_WIDTH_DEF = 8;
  localparam int DIM_W          = 4;
  localparam int CNT_W          = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPEN      = 3'd1,
    ST_FILL      = 3'd2,
    ST_PAD       = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_WAIT_DONE = 3'd5
  } mic_state_t;

  // A dimension is legal when it lies in 1..max_d.
  function automatic logic dim_legal(input logic [DIM_W-1:0] d,
                                     input logic [DIM_W-1:0] max_d);
    return (d != '0) && (d <= max_d);
  endfunction

endpackage

// File: rtl/matrix_input_ctrl_idle_timer.sv
// Counts consecutive idle cycles; expired is high on the TIMEOUT_CYC-th
// consecutive tick cycle since the last clear.
module idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Idle counter: cleared by the owner, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = tick && (count == LIMIT);

endmodule

// File: rtl/matrix_input_ctrl.sv
// Matrix input controller: accepts an m x n matrix entry from the parser,
// forwards exactly m*n elements to storage, zero-padding short input and
// discarding surplus input, then waits for storage to finish.
// Handshake: a beat transfers on a rising clk edge when in_valid and
// in_ready are both high; in_data/in_last are only meaningful with in_valid.
module matrix_input_ctrl
  import matrix_pkg::*;
#(
  parameter int MAX_DIM     = MAX_DIM_DEF,
  parameter int ELEM_WIDTH  = ELEM_WIDTH_DEF,
  parameter int ELEM_MAX    = 9,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            cfg_m,
  input  logic [3:0]            cfg_n,
  input  logic [ELEM_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  st_wen,
  output logic [3:0]            st_m,
  output logic [3:0]            st_n,
  output logic [ELEM_WIDTH-1:0] st_elem,
  output logic                  st_elem_valid,
  input  logic                  st_input_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err_dim,
  output logic                  err_elem,
  output logic                  padded,
  output logic                  truncated
);

  localparam logic [DIM_W-1:0]      MAX_DIM_L  = DIM_W'(MAX_DIM);
  localparam logic [ELEM_WIDTH-1:0] ELEM_MAX_L = ELEM_WIDTH'(ELEM_MAX);

  mic_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, target, target_n, cnt_inc;
  logic [3:0] st_m_n, st_n_n;
  logic [ELEM_WIDTH-1:0] st_elem_n;
  logic in_ready_n, st_wen_n, st_elem_valid_n, busy_n, done_n;
  logic err_dim_n, err_elem_n, padded_n, truncated_n;
  logic accept, tmr_clear, tmr_tick, tmr_expired;

  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign tmr_tick  = (state == ST_FILL) || (state == ST_DRAIN);
  // Clearing on the last cycle of a state makes the count start at zero on entry.
  assign tmr_clear = accept || (state_n != state);

  idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // State and output registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      target        <= '0;
      in_ready      <= 1'b0;
      st_wen        <= 1'b0;
      st_m          <= '0;
      st_n          <= '0;
      st_elem       <= '0;
      st_elem_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_dim       <= 1'b0;
      err_elem      <= 1'b0;
      padded        <= 1'b0;
      truncated     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      target        <= target_n;
      in_ready      <= in_ready_n;
      st_wen        <= st_wen_n;
      st_m          <= st_m_n;
      st_n          <= st_n_n;
      st_elem       <= st_elem_n;
      st_elem_valid <= st_elem_valid_n;
      busy          <= busy_n;
      done          <= done_n;
      err_dim       <= err_dim_n;
      err_elem      <= err_elem_n;
      padded        <= padded_n;
      truncated     <= truncated_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    target_n        = target;
    st_m_n          = st_m;
    st_n_n          = st_n;
    st_elem_n       = st_elem;
    st_elem_valid_n = 1'b0;
    err_elem_n      = 1'b0;
    err_dim_n       = 1'b0;
    done_n          = 1'b0;
    padded_n        = padded;
    truncated_n     = truncated;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dim_legal(cfg_m, MAX_DIM_L) && dim_legal(cfg_n, MAX_DIM_L)) begin
            st_m_n      = cfg_m;
            st_n_n      = cfg_n;
            // 5-bit operands keep the full product (at most 25).
            target_n    = {1'b0, cfg_m} * {1'b0, cfg_n};
            cnt_n       = '0;
            padded_n    = 1'b0;
            truncated_n = 1'b0;
            state_n     = ST_OPEN;
          end else begin
            err_dim_n = 1'b1;
          end
        end
      end
      ST_OPEN: state_n = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          st_elem_valid_n = 1'b1;
          cnt_n           = cnt_inc;
          if (in_data > ELEM_MAX_L) begin
            st_elem_n  = '0;
            err_elem_n = 1'b1;
          end else begin
            st_elem_n = in_data;
          end
          if (cnt_inc == target) begin
            if (in_last) begin
              state_n = ST_WAIT_DONE;
            end else begin
              state_n     = ST_DRAIN;
              truncated_n = 1'b1;
            end
          end else if (in_last) begin
            state_n  = ST_PAD;
            padded_n = 1'b1;
          end
        end else if (tmr_expired) begin
          state_n  = ST_PAD;
          padded_n = 1'b1;
        end
      end
      ST_PAD: begin
        if (cnt < target) begin
          st_elem_valid_n = 1'b1;
          st_elem_n       = '0;
          cnt_n           = cnt_inc;
          if (cnt_inc == target) state_n = ST_WAIT_DONE;
        end else begin
          state_n = ST_WAIT_DONE;
        end
      end
      ST_DRAIN: begin
        if ((accept && in_last) || (!accept && tmr_expired)) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (st_input_done) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    in_ready_n = (state_n == ST_FILL) || (state_n == ST_DRAIN);
    busy_n     = (state_n != ST_IDLE);
    st_wen_n   = (state_n == ST_OPEN);
  end

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Directed bench for matrix_input_ctrl: clock/reset, driver tasks, a
// scoreboard of forwarded elements and one task per scenario.
module tb_matrix_input_ctrl;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_m = '0, cfg_n = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_last = 1'b0, st_input_done = 1'b0;
  logic       in_ready, st_wen, st_elem_valid, busy, done, err_dim, err_elem, padded, truncated;
  logic [3:0] st_m, st_n;
  logic [7:0] st_elem;
  logic [24:0] all_out;

  int n_checks = 0;
  int n_fail = 0;
  bit to_flag = 0;
  int wen_cnt = 0, done_cnt = 0, errdim_cnt = 0, busy_cnt = 0;
  logic [7:0] obs_q[$];
  logic       obs_err_q[$];
  logic [7:0] exp_q[$];
  logic       exp_err_q[$];

  matrix_input_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .st_wen(st_wen), .st_m(st_m), .st_n(st_n), .st_elem(st_elem),
    .st_elem_valid(st_elem_valid), .st_input_done(st_input_done), .busy(busy),
    .done(done), .err_dim(err_dim), .err_elem(err_elem), .padded(padded),
    .truncated(truncated)
  );

  assign all_out = {in_ready, st_wen, st_m, st_n, st_elem, st_elem_valid, busy,
                    done, err_dim, err_elem, padded, truncated};

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Storage-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (st_elem_valid) begin
      obs_q.push_back(st_elem);
      obs_err_q.push_back(err_elem);
    end
    if (st_wen) wen_cnt++;
    if (done) done_cnt++;
    if (err_dim) errdim_cnt++;
    if (busy) busy_cnt++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_sb();
    obs_q.delete(); obs_err_q.delete(); exp_q.delete(); exp_err_q.delete();
    wen_cnt = 0; done_cnt = 0; errdim_cnt = 0; busy_cnt = 0; to_flag = 0;
  endtask

  task automatic do_start(input logic [3:0] m, input logic [3:0] n);
    cfg_m = m; cfg_n = n; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int k = 0;
    while (in_ready !== 1'b1 && k < 50) begin tick(1); k++; end
    if (in_ready !== 1'b1) to_flag = 1;
    in_data = d; in_valid = 1'b1; in_last = last;
    tick(1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin tick(1); k++; end
    if (obs_q.size() < n) to_flag = 1;
  endtask

  task automatic pulse_input_done();
    st_input_done = 1'b1;
    tick(1);
    st_input_done = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst = 1'b1; tick(3);
    n_checks++; if (all_out !== 25'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst = 1'b0; tick(2);
    n_checks++; if (all_out !== 25'd0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", all_out); end
  endtask

  task automatic test_full();
    clear_sb();
    do_start(4'd2, 4'd3);
    n_checks++; if ({st_wen, st_m, st_n, busy, in_ready} !== {1'b1, 4'd2, 4'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL full_open: got %h expected %h", {st_wen, st_m, st_n, busy, in_ready}, {1'b1, 4'd2, 4'd3, 1'b1, 1'b0}); end
    tick(1);
    n_checks++; if ({st_wen, in_ready} !== 2'b01) begin n_fail++; $display("FAIL full_fill_entry: got %b expected 01", {st_wen, in_ready}); end
    send_beat(8'd1, 1'b0);
    do_start(4'd1, 4'd1);
    n_checks++; if ({st_m, st_n} !== {4'd2, 4'd3}) begin n_fail++; $display("FAIL full_start_ignored: got %h expected 23", {st_m, st_n}); end
    for (int i = 2; i <= 6; i++) send_beat(8'(i), i == 6);
    wait_obs(6, 20);
    tick(2);
    for (int i = 1; i <= 6; i++) begin exp_q.push_back(8'(i)); exp_err_q.push_back(1'b0); end
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++; if ({obs_q[i], obs_err_q[i]} !== {exp_q[i], exp_err_q[i]}) begin n_fail++; $display("FAIL full_elem[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i], obs_err_q[i], exp_q[i], exp_err_q[i]); end
    end
    n_checks++; if ({in_ready, busy, done_cnt} !== {1'b0, 1'b1, 32'd0}) begin n_fail++; $display("FAIL full_wait_done: ready=%b busy=%b dones=%0d expected 0 1 0", in_ready, busy, done_cnt); end
    pulse_input_done();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", done); end
    tick(1);
    n_checks++; if ({done, busy, padded, truncated} !== 4'b0000) begin n_fail++; $display("FAIL full_after: got %b expected 0000", {done, busy, padded, truncated}); end
    n_checks++; if (wen_cnt !== 1) begin n_fail++; $display("FAIL full_wen_count: got %0d expected 1", wen_cnt); end
    n_checks++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL full_timeout: handshake wait expired"); end
  endtask

  task automatic test_pad();
    clear_sb();
    do_start(4'd2, 4'd2);
    send_beat(8'd7, 1'b0);
    send_beat(8'd8, 1'b1);
    wait_obs(4, 20);
    tick(2);
    exp_q = '{8'd7, 8'd8, 8'd0, 8'd0};
    n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL pad_count: got %0d expected 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++; if ({obs_q[i], obs_err_q[i]} !== {exp_q[i], 1'b0}) begin n_fail++; $display("FAIL pad_elem[%0d]: got %0d/%0d expected %0d/0", i, obs_q[i], obs_err_q[i], exp_q[i]); end
    end
    n_checks++; if ({padded, truncated, in_ready} !== 3'b100) begin n_fail++; $display("FAIL pad_flags: got %b expected 100", {padded, truncated, in_ready}); end
    pulse_input_done();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pad_done: got %b expected 1", done); end
    tick(1);
    n_checks++; if ({busy, padded} !== 2'b01) begin n_fail++; $display("FAIL pad_sticky: got %b expected 01", {busy, padded}); end
    n_checks++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL pad_timeout: handshake wait expired"); end
  endtask

  task automatic test_truncate();
    clear_sb();
    do_start(4'd1, 4'd2);
    n_checks++; if (padded !== 1'b0) begin n_fail++; $display("FAIL trunc_padded_clear: got %b expected 0", padded); end
    send_beat(8'd3, 1'b0);
    send_beat(8'd4, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd6, 1'b1);
    tick(4);
    exp_q = '{8'd3, 8'd4};
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL trunc_count: got %0d expected 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL trunc_elem[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if ({truncated, padded, in_ready, busy} !== 4'b1001) begin n_fail++; $display("FAIL trunc_flags: got %b expected 1001", {truncated, padded, in_ready, busy}); end
    pulse_input_done();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL trunc_done: got %b expected 1", done); end
    tick(1);
    n_checks++; if ({done_cnt, to_flag} !== {32'd1, 1'b0}) begin n_fail++; $display("FAIL trunc_end: dones=%0d to=%b expected 1 0", done_cnt, to_flag); end
  endtask

  task automatic test_err_dim();
    clear_sb();
    do_start(4'd6, 4'd1);
    n_checks++; if ({err_dim, busy, st_wen} !== 3'b100) begin n_fail++; $display("FAIL errdim_m6: got %b expected 100", {err_dim, busy, st_wen}); end
    tick(1);
    n_checks++; if (err_dim !== 1'b0) begin n_fail++; $display("FAIL errdim_pulse: got %b expected 0", err_dim); end
    do_start(4'd0, 4'd3);
    n_checks++; if ({err_dim, busy} !== 2'b10) begin n_fail++; $display("FAIL errdim_m0: got %b expected 10", {err_dim, busy}); end
    do_start(4'd3, 4'd0);
    n_checks++; if ({err_dim, busy} !== 2'b10) begin n_fail++; $display("FAIL errdim_n0: got %b expected 10", {err_dim, busy}); end
    tick(3);
    n_checks++; if ({wen_cnt, busy_cnt, errdim_cnt} !== {32'd0, 32'd0, 32'd3}) begin n_fail++; $display("FAIL errdim_counts: wen=%0d busy=%0d err=%0d expected 0 0 3", wen_cnt, busy_cnt, errdim_cnt); end
  endtask

  task automatic test_timeout();
    clear_sb();
    do_start(4'd1, 4'd3);
    send_beat(8'd12, 1'b0);
    tick(TO - 10);
    n_checks++; if ({obs_q.size(), in_ready} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL tmo_early: count=%0d ready=%b expected 1 1", obs_q.size(), in_ready); end
    wait_obs(3, 50);
    tick(2);
    exp_q = '{8'd0, 8'd0, 8'd0};
    exp_err_q = '{1'b1, 1'b0, 1'b0};
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL tmo_count: got %0d expected 3", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++; if ({obs_q[i], obs_err_q[i]} !== {exp_q[i], exp_err_q[i]}) begin n_fail++; $display("FAIL tmo_elem[%0d]: got %0d/%0d expected %0d/%0d", i, obs_q[i], obs_err_q[i], exp_q[i], exp_err_q[i]); end
    end
    n_checks++; if ({padded, truncated} !== 2'b10) begin n_fail++; $display("FAIL tmo_flags: got %b expected 10", {padded, truncated}); end
    pulse_input_done();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b expected 1", done); end
    n_checks++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL tmo_wait: handshake wait expired"); end
    tick(1);
  endtask

  task automatic test_reset_mid();
    clear_sb();
    do_start(4'd2, 4'd2);
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b0);
    rst = 1'b1;
    tick(1);
    n_checks++; if (all_out !== 25'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", all_out); end
    rst = 1'b0;
    tick(6);
    n_checks++; if ({obs_q.size(), done_cnt, busy} !== {32'd2, 32'd0, 1'b0}) begin n_fail++; $display("FAIL rstmid_abandon: elems=%0d dones=%0d busy=%b expected 2 0 0", obs_q.size(), done_cnt, busy); end
    clear_sb();
    do_start(4'd1, 4'd1);
    n_checks++; if ({st_wen, st_m, st_n} !== {1'b1, 4'd1, 4'd1}) begin n_fail++; $display("FAIL rstmid_restart: got %h expected 111", {st_wen, st_m, st_n}); end
    send_beat(8'd9, 1'b1);
    tick(1);
    n_checks++; if ({in_ready, padded, truncated, busy} !== 4'b0001) begin n_fail++; $display("FAIL one_by_one_flags: got %b expected 0001", {in_ready, padded, truncated, busy}); end
    n_checks++; if (obs_q.size() !== 1 || obs_q[0] !== 8'd9) begin n_fail++; $display("FAIL one_by_one_elem: count=%0d first=%0d expected 1 9", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'd0); end
    pulse_input_done();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL one_by_one_done: got %b expected 1", done); end
    n_checks++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait: handshake wait expired"); end
    tick(1);
  endtask

  // Test sequence and summary
  initial begin
    test_reset();
    test_full();
    test_pad();
    test_truncate();
    test_err_dim();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
